// File: rtl/i2c_arbiter_pkg.sv
// Shared types and constants for the i2c_arbiter block: FSM states, master
// status bit positions and command opcodes.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        SETTLE   = 3'd2,
        WAITDONE = 3'd3,
        RESP     = 3'd4
    } arb_state_e;

    localparam int STS_BUSY = 63;
    localparam int STS_ERR  = 62;
    localparam int STS_TMO  = 61;

    localparam int CMD_W = 64;

    typedef enum logic [1:0] {
        OP_DONE    = 2'b00,
        OP_RESTART = 2'b01,
        OP_READ    = 2'b10,
        OP_WRITE   = 2'b11
    } i2c_op_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_arbiter_if.sv
// Requester-side and master-side signal bundle of the i2c_arbiter.
// The arbiter uses the slave modport; the parent/bench drives through master.
interface i2c_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*64-1:0] cmd;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [63:0]        rsp;
    logic               busy;
    logic               m_wrcmd;
    logic [63:0]        m_command;
    logic [63:0]        m_status;
    logic               m_abort;

    modport slave (
        input  req, cmd, m_status,
        output gnt, done, rsp, busy, m_wrcmd, m_command, m_abort
    );

    modport master (
        output req, cmd, m_status,
        input  gnt, done, rsp, busy, m_wrcmd, m_command, m_abort
    );
endinterface

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// rr+1, wrapping modulo NREQ. Returns one-hot, index and an any-request flag.
module i2c_rr_pick
    import i2c_arb_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr,
    output logic [NREQ-1:0] onehot,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    int cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        // k = NREQ wraps back to rr itself, so the last winner goes last
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(rr) + k) % NREQ;
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = IDXW'(cand);
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2cmaster between NREQ requesters.
// Optional watchdog/abort path enabled by the macro I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int          NREQ           = 2,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input logic           CLOCK,
    input logic           RESET_N,
    i2c_arbiter_if.slave  bus
);

    localparam int IDXW = idx_width(NREQ);

    if (NREQ < 1 || NREQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("i2c_arbiter: parameter out of range");
    end

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [63:0]     rsp_q, rsp_d;
    logic [63:0]     m_command_q, m_command_d;
    logic            busy_q, busy_d;
    logic            m_wrcmd_q, m_wrcmd_d;
    logic            m_abort_q, m_abort_d;
    logic [IDXW-1:0] rr_q, rr_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [31:0]     tmo_cnt_q, tmo_cnt_d;
`endif

    i2c_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (bus.req),
        .rr     (rr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        rsp_d       = rsp_q;
        m_command_d = m_command_q;
        m_wrcmd_d   = 1'b0;
        m_abort_d   = 1'b0;
        rr_d        = rr_q;
`ifdef I2C_ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d       = pick_onehot;
                    rr_d        = pick_idx;
                    m_command_d = bus.cmd[CMD_W*int'(pick_idx) +: CMD_W];
                    m_wrcmd_d   = 1'b1;
                    state_d     = ISSUE;
`ifdef I2C_ARB_TIMEOUT_EN
                    tmo_cnt_d   = '0;
`endif
                end
            end
            ISSUE: state_d = SETTLE;
            // Dead cycle: the master raises busy on the wrcmd edge
            SETTLE: begin
                state_d = WAITDONE;
`ifdef I2C_ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
            end
            WAITDONE: begin
`ifdef I2C_ARB_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
                if (!bus.m_status[STS_BUSY]) begin
                    rsp_d   = bus.m_status;
                    done_d  = gnt_q;
                    state_d = RESP;
                end
`ifdef I2C_ARB_TIMEOUT_EN
                else if (tmo_cnt_q >= TIMEOUT_CYCLES) begin
                    rsp_d           = bus.m_status;
                    rsp_d[STS_BUSY] = 1'b0;
                    rsp_d[STS_ERR]  = 1'b1;
                    rsp_d[STS_TMO]  = 1'b1;
                    m_abort_d       = 1'b1;
                    done_d          = gnt_q;
                    state_d         = RESP;
                end
`endif
            end
            RESP: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            rsp_q       <= '0;
            m_command_q <= '0;
            busy_q      <= 1'b0;
            m_wrcmd_q   <= 1'b0;
            m_abort_q   <= 1'b0;
            rr_q        <= IDXW'(NREQ - 1);
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rsp_q       <= rsp_d;
            m_command_q <= m_command_d;
            busy_q      <= busy_d;
            m_wrcmd_q   <= m_wrcmd_d;
            m_abort_q   <= m_abort_d;
            rr_q        <= rr_d;
`ifdef I2C_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.rsp       = rsp_q;
    assign bus.busy      = busy_q;
    assign bus.m_wrcmd   = m_wrcmd_q;
    assign bus.m_command = m_command_q;
    assign bus.m_abort   = m_abort_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: behavioural i2cmaster model plus a round-robin
// reference model; the timeout scenario runs when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_arbiter;
    import i2c_arb_pkg::*;

    localparam int          NREQ = 2;
    localparam int unsigned TMO  = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_arbiter_if #(.NREQ(NREQ)) ifc ();

    i2c_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK   (clk),
        .RESET_N (rst_n),
        .bus     (ifc)
    );

    int vectors = 0;
    int miscompares = 0;

    // Master model state and programming knobs
    int          cyc = 0;
    int          clr_cyc = -1;
    int          m_lat = 3;
    logic [63:0] m_final = '0;
    bit          m_stuck = 1'b0;
    int          m_cnt = 0;
    logic [63:0] m_final_l = '0;
    bit          m_busy = 1'b0;

    logic [63:0] cmd_w [NREQ];
    int          model_last = NREQ - 1;

    always_comb begin
        ifc.cmd = '0;
        for (int i = 0; i < NREQ; i++) ifc.cmd[64*i +: 64] = cmd_w[i];
    end

    // i2cmaster: busy from the wrcmd edge for m_lat+1 cycles, then final status.
    // m_abort acts as the master reset, as the parent wires it.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n || ifc.m_abort) begin
            ifc.m_status <= '0;
            m_busy       <= 1'b0;
        end else if (ifc.m_wrcmd) begin
            ifc.m_status <= {1'b1, 63'h0};
            m_busy       <= 1'b1;
            m_cnt        <= m_lat;
            m_final_l    <= {1'b0, m_final[62:0]};
        end else if (m_busy && !m_stuck) begin
            if (m_cnt == 0) begin
                ifc.m_status <= m_final_l;
                m_busy       <= 1'b0;
                clr_cyc      <= cyc + 1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Round-robin rule: first pending requester strictly after the last winner.
    function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++)
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [63:0] rand_status();
        logic [63:0] s;
        s = {$urandom(), $urandom()};
        s[63] = 1'b0;
        return s;
    endfunction

    // Watches one transaction from the current negedge until done (bounded).
    task automatic observe_txn(input int max_cyc, input int drop_after,
                               output int gidx, output logic [63:0] cmd_seen,
                               output int gnt_cyc, output int wr_cyc, output int done_cyc,
                               output logic [NREQ-1:0] done_seen, output logic [NREQ-1:0] gnt_at_done,
                               output logic [63:0] rsp_seen, output int wr_pulses,
                               output int abort_pulses, output int abort_cyc, output bit expired);
        gidx = -1; cmd_seen = '0; gnt_cyc = -1; wr_cyc = -1; done_cyc = -1;
        done_seen = '0; gnt_at_done = '0; rsp_seen = '0; wr_pulses = 0;
        abort_pulses = 0; abort_cyc = -1; expired = 1'b1;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (ifc.m_wrcmd) begin
                wr_pulses++;
                if (wr_cyc < 0) wr_cyc = cyc;
            end
            if (ifc.m_abort) begin
                abort_pulses++;
                abort_cyc = cyc;
            end
            if (gidx < 0 && ifc.gnt != '0) begin
                gnt_cyc  = cyc;
                cmd_seen = ifc.m_command;
                for (int i = 0; i < NREQ; i++) if (ifc.gnt[i]) gidx = i;
            end
            if (drop_after > 0 && gnt_cyc >= 0 && cyc - gnt_cyc == drop_after) ifc.req = '0;
            if (ifc.done != '0) begin
                done_cyc    = cyc;
                done_seen   = ifc.done;
                gnt_at_done = ifc.gnt;
                rsp_seen    = ifc.rsp;
                expired     = 1'b0;
                break;
            end
        end
    endtask

    task automatic do_reset();
        ifc.req = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_last = NREQ - 1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (ifc.gnt !== '0) begin miscompares++; $display("FAIL reset_gnt: got %b expected 0", ifc.gnt); end
        vectors++; if (ifc.done !== '0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", ifc.done); end
        vectors++; if (ifc.rsp !== '0) begin miscompares++; $display("FAIL reset_rsp: got %h expected 0", ifc.rsp); end
        vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", ifc.busy); end
        vectors++; if (ifc.m_wrcmd !== 1'b0) begin miscompares++; $display("FAIL reset_wrcmd: got %b expected 0", ifc.m_wrcmd); end
        vectors++; if (ifc.m_command !== '0) begin miscompares++; $display("FAIL reset_command: got %h expected 0", ifc.m_command); end
        vectors++; if (ifc.m_abort !== 1'b0) begin miscompares++; $display("FAIL reset_abort: got %b expected 0", ifc.m_abort); end
        rst_n = 1'b1;
        model_last = NREQ - 1;
        @(negedge clk);
        vectors++; if (ifc.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", ifc.busy); end
    endtask

    task automatic test_single();
        int gidx, gc, wc, dc, wp, ap, ac, req_cyc;
        logic [63:0] cs, rs;
        logic [NREQ-1:0] ds, gd;
        bit ex;
        cmd_w[0] = 64'hE8C0_0000_0000_0000;
        m_lat    = $urandom_range(1, 6);
        m_final  = {2'b00, 46'h0, 16'($urandom())};
        req_cyc  = cyc;
        ifc.req  = 2'b01;
        observe_txn(200, 0, gidx, cs, gc, wc, dc, ds, gd, rs, wp, ap, ac, ex);
        vectors++; if (ex) begin miscompares++; $display("FAIL single_timeout: got no done expected done"); end
        vectors++; if (gidx != 0) begin miscompares++; $display("FAIL single_gnt: got %0d expected 0", gidx); end
        vectors++; if (wc != req_cyc + 1) begin miscompares++; $display("FAIL single_wr_latency: got cycle %0d expected %0d", wc, req_cyc + 1); end
        vectors++; if (wp != 1) begin miscompares++; $display("FAIL single_wr_pulses: got %0d expected 1", wp); end
        vectors++; if (cs !== 64'hE8C0_0000_0000_0000) begin miscompares++; $display("FAIL single_command: got %h expected e8c0000000000000", cs); end
        vectors++; if (dc != clr_cyc + 1) begin miscompares++; $display("FAIL single_done_latency: got cycle %0d expected %0d", dc, clr_cyc + 1); end
        vectors++; if (ds !== 2'b01 || gd !== 2'b01) begin miscompares++; $display("FAIL single_done_bits: got done %b gnt %b expected 01/01", ds, gd); end
        vectors++; if (rs !== m_final) begin miscompares++; $display("FAIL single_rsp: got %h expected %h", rs, m_final); end
        model_last = 0;
        ifc.req = '0;
        @(negedge clk);
        vectors++; if (ifc.done !== '0 || ifc.gnt !== '0) begin miscompares++; $display("FAIL single_after: got done %b gnt %b expected 0/0", ifc.done, ifc.gnt); end
        vectors++; if (ifc.rsp !== m_final) begin miscompares++; $display("FAIL single_rsp_hold: got %h expected %h", ifc.rsp, m_final); end
    endtask

    task automatic test_back_to_back();
        int gidx, gc, wc, dc, wp, ap, ac, exp, prev_done;
        logic [63:0] cs, rs, exp_rsp;
        logic [NREQ-1:0] ds, gd;
        bit ex;
        do_reset();
        for (int i = 0; i < NREQ; i++) cmd_w[i] = {$urandom(), $urandom()};
        prev_done = -1;
        ifc.req = 2'b11;
        for (int t = 0; t < 6; t++) begin
            m_lat   = $urandom_range(0, 5);
            m_final = rand_status();
            exp_rsp = m_final;
            exp     = model_pick(ifc.req, model_last);
            observe_txn(200, 0, gidx, cs, gc, wc, dc, ds, gd, rs, wp, ap, ac, ex);
            vectors++; if (ex || gidx != exp) begin miscompares++; $display("FAIL b2b_order[%0d]: got %0d expected %0d", t, gidx, exp); end
            vectors++; if (cs !== cmd_w[exp]) begin miscompares++; $display("FAIL b2b_command[%0d]: got %h expected %h", t, cs, cmd_w[exp]); end
            vectors++; if (rs !== exp_rsp) begin miscompares++; $display("FAIL b2b_rsp[%0d]: got %h expected %h", t, rs, exp_rsp); end
            if (t > 0) begin
                vectors++; if (gc - prev_done != 2) begin miscompares++; $display("FAIL b2b_gap[%0d]: got %0d cycles expected 2", t, gc - prev_done); end
            end
            prev_done  = dc;
            model_last = exp;
            cmd_w[exp] = {$urandom(), $urandom()};
        end
        ifc.req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_nak();
        int gidx, gc, wc, dc, wp, ap, ac, exp;
        logic [63:0] cs, rs;
        logic [NREQ-1:0] ds, gd;
        bit ex;
        m_lat   = 6;
        m_final = 64'h4000_0000_0000_0000;
        ifc.req = '0;
        ifc.req[$urandom_range(0, NREQ - 1)] = 1'b1;
        exp = model_pick(ifc.req, model_last);
        // req is withdrawn three cycles into the transaction; done must still come
        observe_txn(200, 3, gidx, cs, gc, wc, dc, ds, gd, rs, wp, ap, ac, ex);
        vectors++; if (ex || gidx != exp) begin miscompares++; $display("FAIL nak_gnt: got %0d expected %0d", gidx, exp); end
        vectors++; if (rs !== 64'h4000_0000_0000_0000) begin miscompares++; $display("FAIL nak_rsp: got %h expected 4000000000000000", rs); end
        vectors++; if (ds !== NREQ'(1 << exp)) begin miscompares++; $display("FAIL nak_done: got %b expected one-hot %0d", ds, exp); end
        vectors++; if (ap != 0) begin miscompares++; $display("FAIL nak_abort: got %0d pulses expected 0", ap); end
        model_last = exp;
        @(negedge clk);
    endtask

    task automatic test_read();
        int gidx, gc, wc, dc, wp, ap, ac, exp;
        logic [63:0] cs, rs, nxt;
        logic [NREQ-1:0] ds, gd;
        bit ex;
        m_lat   = 4;
        m_final = 64'h0000_0000_0000_005A;
        ifc.req = '0;
        ifc.req[$urandom_range(0, NREQ - 1)] = 1'b1;
        exp = model_pick(ifc.req, model_last);
        cmd_w[exp] = {OP_READ, 62'($urandom())};
        observe_txn(200, 0, gidx, cs, gc, wc, dc, ds, gd, rs, wp, ap, ac, ex);
        vectors++; if (ex || gidx != exp) begin miscompares++; $display("FAIL read_gnt: got %0d expected %0d", gidx, exp); end
        vectors++; if (rs[7:0] !== 8'h5A || rs !== m_final) begin miscompares++; $display("FAIL read_rsp: got %h expected 000000000000005a", rs); end
        model_last = exp;
        ifc.req = '0;
        repeat (6) @(negedge clk);
        vectors++; if (ifc.rsp !== 64'h0000_0000_0000_005A) begin miscompares++; $display("FAIL read_rsp_hold: got %h expected 000000000000005a", ifc.rsp); end
        vectors++; if (ifc.done !== '0 || ifc.busy !== 1'b0) begin miscompares++; $display("FAIL read_idle: got done %b busy %b expected 0/0", ifc.done, ifc.busy); end
        nxt     = rand_status();
        m_final = nxt;
        ifc.req = '0;
        ifc.req[$urandom_range(0, NREQ - 1)] = 1'b1;
        exp = model_pick(ifc.req, model_last);
        observe_txn(200, 0, gidx, cs, gc, wc, dc, ds, gd, rs, wp, ap, ac, ex);
        vectors++; if (ex || rs !== nxt) begin miscompares++; $display("FAIL read_rsp_update: got %h expected %h", rs, nxt); end
        model_last = exp;
        ifc.req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int gidx, gc, wc, dc, wp, ap, ac, exp, w;
        logic [63:0] cs, rs;
        logic [NREQ-1:0] ds, gd;
        bit ex;
        m_lat = 40;
        w = $urandom_range(0, NREQ - 1);
        ifc.req = '0;
        ifc.req[w] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ifc.gnt != '0) break;
        end
        vectors++; if (ifc.gnt === '0) begin miscompares++; $display("FAIL rstmid_grant: got no grant expected grant"); end
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (ifc.gnt !== '0 || ifc.busy !== 1'b0 || ifc.m_wrcmd !== 1'b0) begin miscompares++; $display("FAIL rstmid_async: got gnt %b busy %b wrcmd %b expected 0", ifc.gnt, ifc.busy, ifc.m_wrcmd); end
        vectors++; if (ifc.done !== '0 || ifc.rsp !== '0) begin miscompares++; $display("FAIL rstmid_done: got done %b rsp %h expected 0", ifc.done, ifc.rsp); end
        @(negedge clk);
        vectors++; if (ifc.done !== '0) begin miscompares++; $display("FAIL rstmid_nodone: got %b expected 0", ifc.done); end
        rst_n = 1'b1;
        model_last = NREQ - 1;
        m_lat = 2;
        m_final = rand_status();
        exp = model_pick(ifc.req, model_last);
        observe_txn(200, 0, gidx, cs, gc, wc, dc, ds, gd, rs, wp, ap, ac, ex);
        vectors++; if (ex || gidx != exp || rs !== m_final) begin miscompares++; $display("FAIL rstmid_recover: got gnt %0d rsp %h expected %0d %h", gidx, rs, exp, m_final); end
        model_last = exp;
        ifc.req = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        int gidx, gc, wc, dc, wp, ap, ac, exp;
        logic [63:0] cs, rs, exp_rsp;
        logic [NREQ-1:0] ds, gd, r;
        bit ex;
        r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
        ifc.req = r;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 1) == 1) cmd_w[i] = {$urandom(), $urandom()};
            m_lat   = $urandom_range(0, 7);
            m_final = rand_status();
            exp_rsp = m_final;
            exp     = model_pick(ifc.req, model_last);
            observe_txn(200, 0, gidx, cs, gc, wc, dc, ds, gd, rs, wp, ap, ac, ex);
            vectors++; if (ex || gidx != exp) begin miscompares++; $display("FAIL rand_gnt[%0d]: got %0d expected %0d", t, gidx, exp); end
            vectors++; if (cs !== cmd_w[exp]) begin miscompares++; $display("FAIL rand_command[%0d]: got %h expected %h", t, cs, cmd_w[exp]); end
            vectors++; if (rs !== exp_rsp || ds !== NREQ'(1 << exp)) begin miscompares++; $display("FAIL rand_rsp[%0d]: got %h done %b expected %h", t, rs, ds, exp_rsp); end
            vectors++; if (wp != 1 || ap != 0) begin miscompares++; $display("FAIL rand_pulses[%0d]: got wr %0d abort %0d expected 1/0", t, wp, ap); end
            model_last = exp;
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            ifc.req = r;
        end
        ifc.req = '0;
        repeat (2) @(negedge clk);
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int gidx, gc, wc, dc, wp, ap, ac, exp;
        logic [63:0] cs, rs;
        logic [NREQ-1:0] ds, gd;
        bit ex;
        m_stuck = 1'b1;
        ifc.req = '0;
        ifc.req[$urandom_range(0, NREQ - 1)] = 1'b1;
        exp = model_pick(ifc.req, model_last);
        observe_txn(400, 0, gidx, cs, gc, wc, dc, ds, gd, rs, wp, ap, ac, ex);
        vectors++; if (ex || gidx != exp) begin miscompares++; $display("FAIL tmo_done: got gnt %0d expired %0d expected %0d", gidx, ex, exp); end
        vectors++; if (ap != 1 || ac != dc) begin miscompares++; $display("FAIL tmo_abort: got %0d pulses at %0d expected 1 at %0d", ap, ac, dc); end
        vectors++; if (dc != gc + int'(TMO) + 2) begin miscompares++; $display("FAIL tmo_latency: got cycle %0d expected %0d", dc, gc + int'(TMO) + 2); end
        vectors++; if (rs[63:61] !== 3'b011 || rs[60:0] !== '0) begin miscompares++; $display("FAIL tmo_rsp: got %h expected 6000000000000000", rs); end
        model_last = exp;
        m_stuck = 1'b0;
        ifc.req = '0;
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        ifc.req = '0;
        for (int i = 0; i < NREQ; i++) cmd_w[i] = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_nak();
        test_read();
        test_reset_mid();
        test_random();
`ifdef I2C_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
